program_counter: RTL and testbench

- Program-counter register for the RV32 core's fetch stage.
- It holds the address of the current instruction and drives the instruction-memory address.
- On every rising clock edge it loads the next-PC value computed by the external next-PC logic (PC+4, branch target or jump target).
- A synchronous reset returns it to a fixed reset vector.

---
 rtl/program_counter.sv | 33 +++
 tb/tb_program_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-stage program counter: loads the externally computed next PC every
// rising edge and returns to RESET_ADDR on a synchronous, active-high reset.
module program_counter #(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   RESET_ADDR = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_nextPC,
  output logic [WIDTH-1:0] o_addr,
  output logic             o_misaligned
);

  logic [WIDTH-1:0] pc_r;

  // Word alignment flag for a 32-bit instruction address.
  function automatic logic misaligned_f(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

  // PC register: reset vector wins over the next-PC input on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_r <= RESET_ADDR;
    end else begin
      pc_r <= i_nextPC;
    end
  end

  assign o_addr       = pc_r;
  assign o_misaligned = misaligned_f(pc_r[1:0]);

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: expected PCs are queued as stimulus
// is driven and compared one edge later.
module tb_program_counter;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_nextPC;
  logic [31:0] o_addr;
  logic        o_misaligned;

  int unsigned n_total;
  int unsigned n_pass;

  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  program_counter #(
    .WIDTH      (32),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_nextPC     (i_nextPC),
    .o_addr       (o_addr),
    .o_misaligned (o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle between edges, queue the expected PC, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic [31:0] nxt);
    logic [31:0] exp_pc;
    @(negedge i_clk);
    i_reset  = rst;
    i_nextPC = nxt;
    exp_q.push_back(rst ? RESET_ADDR : nxt);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp_pc   = exp_q.pop_front();
      model_pc = exp_pc;
      check_eq({tag, "_addr"}, o_addr, exp_pc);
      check_eq({tag, "_mis"}, {31'd0, o_misaligned}, {31'd0, |exp_pc[1:0]});
    end
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    model_pc = 32'h0;
    i_reset  = 1'b1;
    i_nextPC = 32'h0;

    // Reset held for several edges, then released between edges.
    step("reset0", 1'b1, 32'h0);
    step("reset1", 1'b1, 32'h0);
    step("reset2", 1'b1, 32'hDEAD_BEEF);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check_eq("post_deassert", o_addr, RESET_ADDR);

    // Sequential increment and jump.
    step("inc4", 1'b0, model_pc + 32'd4);
    step("inc8", 1'b0, model_pc + 32'd4);
    step("jump40", 1'b0, 32'h40);
    step("inc44", 1'b0, model_pc + 32'd4);

    // Reset priority over a pending next PC, then that next PC loads.
    step("rst_prio", 1'b1, 32'h1234);
    step("after_rst", 1'b0, 32'h1234);

    // Hold by feeding back the current PC.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("hold%0d", i), 1'b0, model_pc);
    end

    // Input changes between edges must not reach the output early.
    @(negedge i_clk);
    i_nextPC = 32'hA5A5_A5A0;
    #1;
    check_eq("no_comb_path0", o_addr, model_pc);
    i_nextPC = 32'h5A5A_5A5C;
    #2;
    check_eq("no_comb_path1", o_addr, model_pc);
    step("late_load", 1'b0, 32'h5A5A_5A5C);

    // Misalignment flag and wrap-around.
    step("mis42", 1'b0, 32'h42);
    step("mis41", 1'b0, 32'h41);
    step("mis43", 1'b0, 32'h43);
    step("top", 1'b0, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 32'h0);
    step("allones", 1'b0, 32'hFFFF_FFFF);

    // Mid-operation reset returns to the vector and holds there.
    step("mid_rst0", 1'b1, 32'h8000_0000);
    step("mid_rst1", 1'b1, 32'h8000_0004);
    step("resume", 1'b0, 32'h100);

    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
